// File: rtl/regfile_pkg.sv
// Shared constants, FSM state type and range helper for the register file dump sequencer.
// Pure declarations: no latency or backpressure of its own.
package regfile_pkg;

   localparam int REG_COUNT = 16;
   localparam int DATA_W    = 16;
   localparam int ADDR_W    = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      READ   = 3'd1,
      EMIT_A = 3'd2,
      EMIT_B = 3'd3,
      FIN    = 3'd4
   } state_t;

   // Inclusive register count; the modulo-16 subtraction makes last<first wrap past 15.
   function automatic logic [ADDR_W:0] range_count(input logic [ADDR_W-1:0] first,
                                                   input logic [ADDR_W-1:0] last);
      logic [ADDR_W-1:0] span;
      span = last - first;
      return {1'b0, span} + (ADDR_W+1)'(1);
   endfunction

endpackage

// File: rtl/regfile_dump_if.sv
// Streamed-word valid/ready bus: master drives data/idx/valid, slave returns ready.
// A word transfers on any clock where out_valid and out_ready are both high.
interface regfile_dump_if #(
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int ADDR_W = regfile_pkg::ADDR_W
);
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_idx;
   logic              out_valid;
   logic              out_ready;

   modport master (output out_data, output out_idx, output out_valid, input out_ready);
   modport slave  (input out_data, input out_idx, input out_valid, output out_ready);
endinterface

// File: rtl/dump_out_stage.sv
// Single-entry registered valid/ready output stage; a pushed word appears one cycle later.
// Accepts a new word when empty or when the held word drains the same cycle; holds otherwise.
module dump_out_stage #(
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int IDX_W  = regfile_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_in_vld,
   input  logic [DATA_W-1:0] i_in_dat,
   input  logic [IDX_W-1:0]  i_in_idx,
   output logic              o_in_rdy,
   output logic              o_out_vld,
   output logic [DATA_W-1:0] o_out_dat,
   output logic [IDX_W-1:0]  o_out_idx,
   input  logic              i_out_rdy
);
   logic              r_vld;
   logic [DATA_W-1:0] r_dat;
   logic [IDX_W-1:0]  r_idx;

   assign o_in_rdy  = !r_vld || i_out_rdy;
   assign o_out_vld = r_vld;
   assign o_out_dat = r_dat;
   assign o_out_idx = r_idx;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_vld <= 1'b0;
         r_dat <= '0;
         r_idx <= '0;
      end else if (i_in_vld && o_in_rdy) begin
         r_vld <= 1'b1;
         r_dat <= i_in_dat;
         r_idx <= i_in_idx;
      end else if (i_out_rdy) begin
         r_vld <= 1'b0;
      end
   end
endmodule

// File: rtl/regfile_dump.sv
// Streams an inclusive, wrapping register range out of the 16x16 register file, two reads per grant.
// First word 2 cycles after start; 2 words per 3 cycles; out_ready low freezes the held word.
module regfile_dump #(
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int ADDR_W = regfile_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] first_reg,
   input  logic [ADDR_W-1:0] last_reg,
   input  logic              rf_grant,
   output logic [ADDR_W-1:0] Rdest,
   output logic [ADDR_W-1:0] Rsrc,
   output logic              EnableWrite,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   regfile_dump_if.master    dout,
   output logic              busy,
   output logic              done
);
   import regfile_pkg::*;

   state_t            r_state;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W-1:0] r_ptr_nxt;
   logic [ADDR_W:0]   r_remaining;
   logic [DATA_W-1:0] r_cap_b;
   logic              r_busy;
   logic              r_done;

   logic              w_push;
   logic [DATA_W-1:0] w_push_dat;
   logic [ADDR_W-1:0] w_push_idx;
   logic              w_in_rdy;
   logic              w_last;

   assign Rdest       = r_ptr;
   assign Rsrc        = r_ptr_nxt;
   assign EnableWrite = 1'b0;
   assign busy        = r_busy;
   assign done        = r_done;
   assign w_last      = (r_remaining == (ADDR_W+1)'(1));

   // Word A goes straight from the read bus into the output stage; word B waits in r_cap_b.
   always_comb begin
      w_push     = 1'b0;
      w_push_dat = A;
      w_push_idx = r_ptr;
      case (r_state)
         READ: begin
            w_push = rf_grant && w_in_rdy;
         end
         EMIT_A: begin
            w_push     = dout.out_ready && !w_last;
            w_push_dat = r_cap_b;
            w_push_idx = r_ptr_nxt;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_ptr_nxt   <= '0;
         r_remaining <= '0;
         r_cap_b     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_ptr       <= first_reg;
                  r_ptr_nxt   <= first_reg + ADDR_W'(1);
                  r_remaining <= range_count(first_reg, last_reg);
                  r_busy      <= 1'b1;
                  r_state     <= READ;
               end
            end
            READ: begin
               if (rf_grant && w_in_rdy) begin
                  r_cap_b <= B;
                  r_state <= EMIT_A;
               end
            end
            EMIT_A: begin
               if (dout.out_ready) begin
                  r_remaining <= r_remaining - (ADDR_W+1)'(1);
                  if (w_last) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= FIN;
                  end else begin
                     r_state <= EMIT_B;
                  end
               end
            end
            EMIT_B: begin
               if (dout.out_ready) begin
                  r_remaining <= r_remaining - (ADDR_W+1)'(1);
                  r_ptr       <= r_ptr + ADDR_W'(2);
                  r_ptr_nxt   <= r_ptr_nxt + ADDR_W'(2);
                  if (w_last) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= FIN;
                  end else begin
                     r_state <= READ;
                  end
               end
            end
            FIN:     r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   dump_out_stage #(
      .DATA_W (DATA_W),
      .IDX_W  (ADDR_W)
   ) u_out (
      .clk       (clk),
      .rst       (rst),
      .i_in_vld  (w_push),
      .i_in_dat  (w_push_dat),
      .i_in_idx  (w_push_idx),
      .o_in_rdy  (w_in_rdy),
      .o_out_vld (dout.out_valid),
      .o_out_dat (dout.out_data),
      .o_out_idx (dout.out_idx),
      .i_out_rdy (dout.out_ready)
   );
endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: directed scenarios plus randomized dumps against a range/array reference.
module tb_regfile_dump;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  first_reg = 4'd0;
   logic [3:0]  last_reg = 4'd0;
   logic        rf_grant = 1'b0;
   logic [3:0]  Rdest, Rsrc;
   logic        EnableWrite;
   logic [15:0] A, B;
   logic        busy, done;
   logic [15:0] rf [16];

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int ew_bad = 0;
   int lat, dlen;

   regfile_dump_if #(.DATA_W(16), .ADDR_W(4)) dif ();

   regfile_dump dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .first_reg   (first_reg),
      .last_reg    (last_reg),
      .rf_grant    (rf_grant),
      .Rdest       (Rdest),
      .Rsrc        (Rsrc),
      .EnableWrite (EnableWrite),
      .A           (A),
      .B           (B),
      .dout        (dif.master),
      .busy        (busy),
      .done        (done)
   );

   // Combinational register file read ports
   assign A = rf[Rdest];
   assign B = rf[Rsrc];

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (EnableWrite !== 1'b0) ew_bad++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input string tag);
      int k = 0;
      while (dif.out_valid !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
      chk(tag, 32'(dif.out_valid), 32'd1);
   endtask

   // Expected stream: indices first, first+1, ... (mod 16), count words, values from rf at start time.
   task automatic do_dump(input logic [3:0] f, input logic [3:0] l, input int gpct, input int rpct,
                          output int lat_o, output int dlen_o);
      int          q_idx[$];
      logic [15:0] q_dat[$];
      int          n, nx, s, first_v, done_at;
      bit          fin, stall;
      logic [15:0] pd;
      logic [3:0]  pi;
      n = ((int'(l) - int'(f) + 16) % 16) + 1;
      for (int k = 0; k < n; k++) begin
         q_idx.push_back((int'(f) + k) % 16);
         q_dat.push_back(rf[(int'(f) + k) % 16]);
      end
      first_reg = f;
      last_reg  = l;
      s = cyc;
      start = 1'b1;
      tick();
      nx = 0; first_v = -1; done_at = -1; fin = 0; stall = 0; pd = '0; pi = '0;
      for (int c = 0; c < 400 && !fin; c++) begin
         if (done === 1'b1) begin
            fin = 1;
            done_at = cyc;
            start = 1'b0;
            chk("done_busy", 32'(busy), 32'd0);
            chk("done_queue_empty", 32'(q_idx.size()), 32'd0);
         end else begin
            chk("busy_during", 32'(busy), 32'd1);
            if (stall) begin
               chk("hold_valid", 32'(dif.out_valid), 32'd1);
               chk("hold_data", 32'(dif.out_data), 32'(pd));
               chk("hold_idx", 32'(dif.out_idx), 32'(pi));
            end
            if (dif.out_valid === 1'b1 && first_v < 0) first_v = cyc;
            rf_grant      = ($urandom_range(99) < gpct);
            dif.out_ready = ($urandom_range(99) < rpct);
            start         = 1'($urandom_range(1));
            first_reg     = 4'($urandom);
            last_reg      = 4'($urandom);
            if (dif.out_valid === 1'b1 && dif.out_ready) begin
               nx++;
               chk("word_expected", 32'(q_idx.size() != 0), 32'd1);
               if (q_idx.size() != 0) begin
                  chk("out_idx", 32'(dif.out_idx), 32'(q_idx.pop_front()));
                  chk("out_data", 32'(dif.out_data), 32'(q_dat.pop_front()));
               end
            end
            stall = (dif.out_valid === 1'b1) && !dif.out_ready;
            pd = dif.out_data;
            pi = dif.out_idx;
            tick();
         end
      end
      start = 1'b0;
      chk("dump_timeout", 32'(fin), 32'd1);
      chk("xfer_count", 32'(nx), 32'(n));
      tick();
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("idle_valid", 32'(dif.out_valid), 32'd0);
      lat_o  = first_v - s;
      dlen_o = done_at - first_v;
   endtask

   initial begin
      dif.out_ready = 1'b0;
      for (int i = 0; i < 16; i++) rf[i] = 16'hA000 + 16'(i);

      // Reset then idle
      tick();
      tick();
      chk("rst_valid", 32'(dif.out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rdest", 32'(Rdest), 32'd0);
      chk("rst_rsrc", 32'(Rsrc), 32'd0);
      chk("rst_data", 32'(dif.out_data), 32'd0);
      chk("rst_idx", 32'(dif.out_idx), 32'd0);
      chk("rst_ew", 32'(EnableWrite), 32'd0);
      rst = 1'b1;
      tick();
      chk("idle_valid", 32'(dif.out_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);

      // Full dump 0..15; first valid counts as cycle 1, so done lands on cycle 24
      do_dump(4'd0, 4'd15, 100, 100, lat, dlen);
      chk("full_latency", 32'(lat), 32'd2);
      chk("full_done_offset", 32'(dlen + 1), 32'd24);

      // Wrap with odd count: 14, 15, 0
      do_dump(4'd14, 4'd0, 100, 100, lat, dlen);
      chk("wrap_latency", 32'(lat), 32'd2);

      // Backpressure: hold R2 for 5 cycles
      first_reg = 4'd2; last_reg = 4'd3; rf_grant = 1'b1; dif.out_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_valid("bp_wait_valid");
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", 32'(dif.out_valid), 32'd1);
         chk("bp_data", 32'(dif.out_data), 32'hA002);
         chk("bp_idx", 32'(dif.out_idx), 32'd2);
         tick();
      end
      dif.out_ready = 1'b1;
      chk("bp_rel_data", 32'(dif.out_data), 32'hA002);
      tick();
      chk("bp_b_valid", 32'(dif.out_valid), 32'd1);
      chk("bp_b_data", 32'(dif.out_data), 32'hA003);
      chk("bp_b_idx", 32'(dif.out_idx), 32'd3);
      tick();
      chk("bp_done", 32'(done), 32'd1);
      chk("bp_end_valid", 32'(dif.out_valid), 32'd0);
      tick();
      chk("bp_done_clear", 32'(done), 32'd0);

      // Grant stall with a write to R2 landing during the stall
      first_reg = 4'd2; last_reg = 4'd3; rf_grant = 1'b0; dif.out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("gs_rdest", 32'(Rdest), 32'd2);
         chk("gs_rsrc", 32'(Rsrc), 32'd3);
         chk("gs_valid", 32'(dif.out_valid), 32'd0);
         if (k == 1) rf[2] = 16'h1234;
         tick();
      end
      rf_grant = 1'b1;
      tick();
      chk("gs_first_data", 32'(dif.out_data), 32'h1234);
      chk("gs_first_idx", 32'(dif.out_idx), 32'd2);
      tick();
      chk("gs_second_data", 32'(dif.out_data), 32'hA003);
      tick();
      chk("gs_done", 32'(done), 32'd1);
      tick();
      rf[2] = 16'hA002;

      // Reset during EMIT_B of a 6-word dump
      first_reg = 4'd0; last_reg = 4'd5; rf_grant = 1'b1; dif.out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("ab_in_emit_b_idx", 32'(dif.out_idx), 32'd1);
      rst = 1'b0;
      tick();
      chk("ab_valid", 32'(dif.out_valid), 32'd0);
      chk("ab_busy", 32'(busy), 32'd0);
      chk("ab_done", 32'(done), 32'd0);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("ab_quiet_valid", 32'(dif.out_valid), 32'd0);
         chk("ab_quiet_done", 32'(done), 32'd0);
      end

      // Single word; random start pulses while busy must be ignored
      do_dump(4'd7, 4'd7, 100, 100, lat, dlen);
      chk("single_latency", 32'(lat), 32'd2);

      // Randomized dumps with random grant and ready
      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < 16; i++) rf[i] = 16'($urandom);
         do_dump(4'($urandom), 4'($urandom), 60, 60, lat, dlen);
      end

      chk("enable_write_low", 32'(ew_bad), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
